// File: rtl/adelie_tb_pkg.sv
// Shared constants for the simulation memory harness and the benches that drive it.
//   XLEN_DEFAULT        default data/address width
//   TOHOST_ADDR_DEFAULT default byte address of the tohost mailbox
//   EXIT_PASS           tohost value that signals a passing test
//   RD_LAT_MAX          largest supported read latency
package adelie_tb_pkg;

  localparam int unsigned XLEN_DEFAULT        = 32;
  localparam logic [31:0] TOHOST_ADDR_DEFAULT = 32'h0000_3FF0;
  localparam int unsigned EXIT_PASS           = 1;
  localparam int unsigned RD_LAT_MAX          = 4;

endpackage

// File: rtl/sim_rd_pipe.sv
// Read-data delay line for one memory port.
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset, clears every stage
//   data_i  word read from the array this cycle
//   data_o  data_i delayed by RD_LAT cycles (RD_LAT = 0: straight through)
module sim_rd_pipe
  import adelie_tb_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEFAULT,
  parameter int unsigned RD_LAT = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] data_i,
  output logic [XLEN-1:0] data_o
);

  if (RD_LAT == 0) begin : g_comb
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
    assign data_o = data_i;
  end else begin : g_pipe
    logic [XLEN-1:0] stage_q [RD_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < RD_LAT; i++) stage_q[i] <= '0;
      end else begin
        stage_q[0] <= data_i;
        for (int i = 1; i < RD_LAT; i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign data_o = stage_q[RD_LAT-1];
  end

endmodule

// File: rtl/sim_mem_harness.sv
// Simulation memory and test-completion harness for core benches.
// Shared I/D word memory with configurable read latency, byte-strobed data writes, a bench
// preload port, a tohost mailbox and a cycle-timeout watchdog.
//   clk, rst_n                 clock, asynchronous active-low reset (memory array is not reset)
//   i_addr / i_rdata           instruction fetch byte address / word after RD_LAT cycles
//   d_addr / d_rdata           data byte address / word after RD_LAT cycles
//   d_wdata, d_we, d_be        data write value, enable, byte enables
//   load_en, load_addr/_data   full-word preload from the bench (wins over d_we on the same word)
//   done, pass, timeout        sticky completion status
//   exit_code                  tohost value >> 1 on a failing tohost, else 0
//   oob_err                    sticky: some port addressed beyond DEPTH_WORDS
module sim_mem_harness
  import adelie_tb_pkg::*;
#(
  parameter int unsigned     XLEN           = XLEN_DEFAULT,
  parameter int unsigned     DEPTH_WORDS    = 4096,
  parameter int unsigned     RD_LAT         = 1,
  parameter logic [XLEN-1:0] TOHOST_ADDR    = XLEN'(TOHOST_ADDR_DEFAULT),
  parameter int unsigned     TIMEOUT_CYCLES = 100000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [XLEN-1:0]   i_addr,
  output logic [XLEN-1:0]   i_rdata,
  input  logic [XLEN-1:0]   d_addr,
  input  logic [XLEN-1:0]   d_wdata,
  input  logic              d_we,
  input  logic [XLEN/8-1:0] d_be,
  output logic [XLEN-1:0]   d_rdata,
  input  logic              load_en,
  input  logic [XLEN-1:0]   load_addr,
  input  logic [XLEN-1:0]   load_data,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [XLEN-1:0]   exit_code,
  output logic              oob_err
);

  localparam int unsigned IdxW     = $clog2(DEPTH_WORDS);
  localparam int unsigned NumBytes = XLEN / 8;

  logic [XLEN-1:0] mem [DEPTH_WORDS];

  logic [IdxW-1:0] i_idx, d_idx, ld_idx;
  logic            i_oob, d_oob, ld_oob;
  logic [XLEN-1:0] i_word, d_word;
  logic            d_wr_en;

  // Byte offset within a word is ignored; no misalignment trap.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{i_addr[1:0], d_addr[1:0], load_addr[1:0]};

  assign i_idx  = i_addr[IdxW+1:2];
  assign d_idx  = d_addr[IdxW+1:2];
  assign ld_idx = load_addr[IdxW+1:2];
  assign i_oob  = (i_addr >> 2) >= XLEN'(DEPTH_WORDS);
  assign d_oob  = (d_addr >> 2) >= XLEN'(DEPTH_WORDS);
  assign ld_oob = (load_addr >> 2) >= XLEN'(DEPTH_WORDS);

  assign i_word = i_oob ? '0 : mem[i_idx];
  assign d_word = d_oob ? '0 : mem[d_idx];

  // The preload port owns a word for the cycle; a colliding core write is dropped.
  assign d_wr_en = d_we && !d_oob && !(load_en && !ld_oob && (ld_idx == d_idx));

  // Array contents survive reset so a bench can reset the core mid-test.
  always_ff @(posedge clk) begin
    if (load_en && !ld_oob) mem[ld_idx] <= load_data;
    if (d_wr_en) begin
      for (int k = 0; k < NumBytes; k++) begin
        if (d_be[k]) mem[d_idx][8*k +: 8] <= d_wdata[8*k +: 8];
      end
    end
  end

  sim_rd_pipe #(
    .XLEN   (XLEN),
    .RD_LAT (RD_LAT)
  ) u_i_pipe (
    .clk    (clk),
    .rst_n  (rst_n),
    .data_i (i_word),
    .data_o (i_rdata)
  );

  sim_rd_pipe #(
    .XLEN   (XLEN),
    .RD_LAT (RD_LAT)
  ) u_d_pipe (
    .clk    (clk),
    .rst_n  (rst_n),
    .data_i (d_word),
    .data_o (d_rdata)
  );

  // Mailbox and watchdog
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic            timeout_q, timeout_d;
  logic            oob_q, oob_d;
  logic [XLEN-1:0] exit_q, exit_d;
  logic [31:0]     cnt_q, cnt_d;
  logic            tohost_hit, wd_expire;

  assign tohost_hit = d_we && (d_addr == TOHOST_ADDR) && (&d_be) && d_wdata[0] && !done_q;
  assign wd_expire  = (TIMEOUT_CYCLES != 0) && !done_q && (cnt_q == TIMEOUT_CYCLES - 1);

  always_comb begin
    done_d    = done_q;
    pass_d    = pass_q;
    timeout_d = timeout_q;
    exit_d    = exit_q;
    cnt_d     = cnt_q;
    // The data port reads every cycle, so a stray d_addr counts as an access.
    oob_d     = oob_q || i_oob || d_oob || (load_en && ld_oob);

    if (!done_q && (cnt_q != '1)) cnt_d = cnt_q + 32'd1;

    // Tohost takes priority over a watchdog expiry in the same cycle.
    if (tohost_hit) begin
      done_d = 1'b1;
      pass_d = (d_wdata == XLEN'(EXIT_PASS));
      exit_d = (d_wdata == XLEN'(EXIT_PASS)) ? '0 : (d_wdata >> 1);
    end else if (wd_expire) begin
      done_d    = 1'b1;
      timeout_d = 1'b1;
      pass_d    = 1'b0;
      exit_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
      exit_q    <= '0;
      oob_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      done_q    <= done_d;
      pass_q    <= pass_d;
      timeout_q <= timeout_d;
      exit_q    <= exit_d;
      oob_q     <= oob_d;
      cnt_q     <= cnt_d;
    end
  end

  assign done      = done_q;
  assign pass      = pass_q;
  assign timeout   = timeout_q;
  assign exit_code = exit_q;
  assign oob_err   = oob_q;

endmodule

// File: tb/tb_sim_mem_harness.sv
module tb_sim_mem_harness;

  localparam logic [31:0] TohostByte = 32'h0000_3FF0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] i_addr, d_addr, d_wdata, load_addr, load_data;
  logic        d_we, load_en;
  logic [3:0]  d_be;

  // m: RD_LAT=1 main, z: RD_LAT=0, t: RD_LAT=3, w: RD_LAT=1 with a 10-cycle watchdog
  logic [31:0] m_i, m_d, m_exit, z_i, z_d, z_exit, t_i, t_d, t_exit, w_i, w_d, w_exit;
  logic        m_done, m_pass, m_to, m_oob, z_done, z_pass, z_to, z_oob;
  logic        t_done, t_pass, t_to, t_oob, w_done, w_pass, w_to, w_oob;

  always #5 clk = ~clk;

  sim_mem_harness #(.RD_LAT(1)) u_m (
    .clk(clk), .rst_n(rst_n), .i_addr(i_addr), .i_rdata(m_i), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_we(d_we), .d_be(d_be), .d_rdata(m_d), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data), .done(m_done), .pass(m_pass),
    .timeout(m_to), .exit_code(m_exit), .oob_err(m_oob));

  sim_mem_harness #(.RD_LAT(0)) u_z (
    .clk(clk), .rst_n(rst_n), .i_addr(i_addr), .i_rdata(z_i), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_we(d_we), .d_be(d_be), .d_rdata(z_d), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data), .done(z_done), .pass(z_pass),
    .timeout(z_to), .exit_code(z_exit), .oob_err(z_oob));

  sim_mem_harness #(.RD_LAT(3)) u_t (
    .clk(clk), .rst_n(rst_n), .i_addr(i_addr), .i_rdata(t_i), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_we(d_we), .d_be(d_be), .d_rdata(t_d), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data), .done(t_done), .pass(t_pass),
    .timeout(t_to), .exit_code(t_exit), .oob_err(t_oob));

  sim_mem_harness #(.RD_LAT(1), .TIMEOUT_CYCLES(10)) u_w (
    .clk(clk), .rst_n(rst_n), .i_addr(i_addr), .i_rdata(w_i), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_we(d_we), .d_be(d_be), .d_rdata(w_d), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data), .done(w_done), .pass(w_pass),
    .timeout(w_to), .exit_code(w_exit), .oob_err(w_oob));

  int total = 0;
  int bad   = 0;

  logic [31:0] model [32];
  logic [31:0] ia [12];
  logic [31:0] da [12];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [31:0] byte_addr, input logic [31:0] val);
    load_en   = 1'b1;
    load_addr = byte_addr;
    load_data = val;
    tick();
    load_en   = 1'b0;
  endtask

  task automatic dwrite(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] val);
    d_addr  = addr;
    d_be    = be;
    d_wdata = val;
    d_we    = 1'b1;
    tick();
    d_we    = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] val,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = val[8*k +: 8];
    return r;
  endfunction

  initial begin
    logic [31:0] v, addr;
    logic [3:0]  be;
    int          idx;

    rst_n = 1'b0; i_addr = '0; d_addr = '0; d_wdata = '0; d_we = 1'b0; d_be = '0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    repeat (2) tick();

    check("rst_i_rdata", m_i, 32'h0);
    check("rst_d_rdata", m_d, 32'h0);
    check("rst_done", 32'(m_done), 32'h0);
    check("rst_pass", 32'(m_pass), 32'h0);
    check("rst_timeout", 32'(m_to), 32'h0);
    check("rst_exit", m_exit, 32'h0);
    check("rst_oob", 32'(m_oob), 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 32; i++) begin
      model[i] = (i == 0) ? 32'h00F0_8193 : $urandom;
      preload(32'(i) * 4, model[i]);
    end
    preload(TohostByte, 32'h0);

    // Latency sweep: 0,4,8 then random, back-to-back on both ports
    for (int c = 0; c < 12; c++) begin
      ia[c]  = (c < 3) ? 32'(c) * 4 : 32'($urandom_range(0, 31)) * 4;
      da[c]  = 32'($urandom_range(0, 31)) * 4;
      i_addr = ia[c];
      d_addr = da[c];
      #1;
      check("lat0_i", z_i, model[ia[c] >> 2]);
      check("lat0_d", z_d, model[da[c] >> 2]);
      @(posedge clk);
      #1;
      check("lat1_i", m_i, model[ia[c] >> 2]);
      check("lat1_d", m_d, model[da[c] >> 2]);
      if (c >= 2) begin
        check("lat3_i", t_i, model[ia[c-2] >> 2]);
        check("lat3_d", t_d, model[da[c-2] >> 2]);
      end
    end

    // Byte strobe with same-cycle old-value read
    preload(32'd64, 32'hFFFF_FFFF);
    model[16] = 32'hFFFF_FFFF;
    d_addr = 32'd64; d_be = 4'b0101; d_wdata = 32'h1122_3344; d_we = 1'b1;
    #1;
    check("be_same_cycle_lat0", z_d, 32'hFFFF_FFFF);
    tick();
    d_we = 1'b0;
    check("be_same_cycle_lat1", m_d, 32'hFFFF_FFFF);
    model[16] = 32'hFF22_FF44;
    #1;
    check("be_new_lat0", z_d, model[16]);
    tick();
    check("be_new_lat1", m_d, model[16]);

    // Random strobed writes, misaligned addresses land on the containing word
    repeat (8) begin
      idx = $urandom_range(0, 31);
      be  = 4'($urandom_range(1, 15));
      v   = $urandom;
      dwrite(32'(idx) * 4 + 32'($urandom_range(0, 3)), be, v);
      model[idx] = merge(model[idx], v, be);
    end
    // Preload and core write on one word: preload wins
    load_en = 1'b1; load_addr = 32'd20; load_data = 32'hA5A5_A5A5;
    dwrite(32'd20, 4'hF, 32'h5A5A_5A5A);
    load_en = 1'b0;
    model[5] = 32'hA5A5_A5A5;
    for (int i = 0; i < 32; i++) begin
      d_addr = 32'(i) * 4;
      tick();
      check("readback", m_d, model[i]);
    end

    // Tohost mailbox
    check("th_pre_done", 32'(m_done), 32'h0);
    dwrite(TohostByte, 4'b0111, 32'h1);
    check("th_partial_done", 32'(m_done), 32'h0);
    dwrite(TohostByte, 4'hF, 32'h2);
    check("th_even_done", 32'(m_done), 32'h0);
    d_addr = TohostByte;
    tick();
    check("th_even_stored", m_d, 32'h2);
    dwrite(TohostByte, 4'hF, 32'h1);
    check("th_pass_done", 32'(m_done), 32'h1);
    check("th_pass_pass", 32'(m_pass), 32'h1);
    check("th_pass_exit", m_exit, 32'h0);
    check("th_pass_timeout", 32'(m_to), 32'h0);
    dwrite(TohostByte, 4'hF, 32'h7);
    check("th_late_pass", 32'(m_pass), 32'h1);
    check("th_late_exit", m_exit, 32'h0);
    d_addr = TohostByte;
    tick();
    check("th_late_stored", m_d, 32'h7);

    // Asynchronous reset mid-cycle; memory survives
    i_addr = 32'd4;
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_i_rdata", m_i, 32'h0);
    check("mid_rst_d_rdata", m_d, 32'h0);
    check("mid_rst_lat3_i", t_i, 32'h0);
    check("mid_rst_done", 32'(m_done), 32'h0);
    check("mid_rst_pass", 32'(m_pass), 32'h0);
    check("mid_rst_exit", m_exit, 32'h0);
    tick();
    rst_n = 1'b1;
    i_addr = 32'd0;
    tick();
    check("mem_after_reset", m_i, 32'h00F0_8193);

    dwrite(TohostByte, 4'hF, 32'h7);
    check("th_fail_done", 32'(m_done), 32'h1);
    check("th_fail_pass", 32'(m_pass), 32'h0);
    check("th_fail_exit", m_exit, 32'h3);
    check("th_fail_timeout", 32'(m_to), 32'h0);
    dwrite(TohostByte, 4'hF, 32'h1);
    check("th_fail_sticky_pass", 32'(m_pass), 32'h0);
    check("th_fail_sticky_exit", m_exit, 32'h3);

    do_reset();
    v = $urandom | 32'h1;
    if (v == 32'h1) v = 32'h3;
    dwrite(TohostByte, 4'hF, v);
    check("th_rand_pass", 32'(m_pass), 32'h0);
    check("th_rand_exit", m_exit, v >> 1);

    // Watchdog, 10-cycle limit: expiry on edge 10 after reset release
    do_reset();
    repeat (9) tick();
    check("wd_edge9_done", 32'(w_done), 32'h0);
    tick();
    check("wd_edge10_done", 32'(w_done), 32'h1);
    check("wd_edge10_timeout", 32'(w_to), 32'h1);
    check("wd_edge10_pass", 32'(w_pass), 32'h0);
    check("wd_edge10_exit", w_exit, 32'h0);
    check("wd_main_not_done", 32'(m_done), 32'h0);
    repeat (5) tick();
    check("wd_sticky", 32'(w_to), 32'h1);

    do_reset();
    repeat (9) tick();
    dwrite(TohostByte, 4'hF, 32'h1);
    check("wd_race_done", 32'(w_done), 32'h1);
    check("wd_race_pass", 32'(w_pass), 32'h1);
    check("wd_race_timeout", 32'(w_to), 32'h0);
    repeat (3) tick();
    check("wd_race_timeout_hold", 32'(w_to), 32'h0);

    // Out-of-range access
    check("oob_pre", 32'(m_oob), 32'h0);
    addr = 32'h0000_4000;
    d_addr = addr; d_be = 4'hF; d_wdata = 32'hDEAD_BEEF; d_we = 1'b1;
    #1;
    check("oob_lat0_rdata", z_d, 32'h0);
    tick();
    d_we = 1'b0;
    check("oob_lat1_rdata", m_d, 32'h0);
    check("oob_set", 32'(m_oob), 32'h1);
    d_addr = 32'd0;
    repeat (3) tick();
    check("oob_sticky", 32'(m_oob), 32'h1);
    for (int i = 0; i < 32; i++) begin
      d_addr = 32'(i) * 4;
      tick();
      check("oob_no_alias", m_d, model[i]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
